// File: rtl/block_color_pkg.sv
// Shared types and constants for the per-tile average colour measurement.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package block_color_pkg;

  localparam int GRID    = 4;
  localparam int NUM_BLK = GRID * GRID;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_SOF  = 3'd1,
    S_ACCUM     = 3'd2,
    S_LATCH     = 3'd3,
    S_START     = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  // Per-channel accumulator width: 8-bit samples, at most 2^(2*win_log2) of them.
  function automatic int acc_width(input int win_log2);
    return 8 + 2 * win_log2;
  endfunction

endpackage

// File: rtl/grid_locator.sv
// Maps a pixel coordinate to its tile index and flags whether it lies in that tile's centre window.
// Latency: purely combinational.
// Backpressure: none.
module grid_locator
  import block_color_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int WIN_LOG2 = 4
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_in_win,
  output logic [3:0]  o_blk_idx
);

  localparam int BLK_W = IMG_W / GRID;
  localparam int BLK_H = IMG_H / GRID;
  localparam int WIN   = 1 << WIN_LOG2;

  localparam logic [11:0] IMG_W_L = 12'(IMG_W);
  localparam logic [11:0] IMG_H_L = 12'(IMG_H);
  localparam logic [11:0] X_LO    = 12'((BLK_W - WIN) / 2);
  localparam logic [11:0] Y_LO    = 12'((BLK_H - WIN) / 2);
  localparam logic [11:0] X_HI    = 12'((BLK_W - WIN) / 2 + WIN);
  localparam logic [11:0] Y_HI    = 12'((BLK_H - WIN) / 2 + WIN);

  logic [1:0]  col;
  logic [1:0]  row;
  logic [11:0] x_off;
  logic [11:0] y_off;

  // Tile column/row by threshold compare rather than a divider; offset is the remainder.
  always_comb begin
    col   = 2'd0;
    row   = 2'd0;
    x_off = i_x;
    y_off = i_y;
    for (int c = 1; c < GRID; c++) begin
      if (i_x >= 12'(c * BLK_W)) begin
        col   = 2'(c);
        x_off = i_x - 12'(c * BLK_W);
      end
      if (i_y >= 12'(c * BLK_H)) begin
        row   = 2'(c);
        y_off = i_y - 12'(c * BLK_H);
      end
    end
  end

  // Out-of-frame coordinates never count as in-window.
  assign o_in_win  = (i_x < IMG_W_L) && (i_y < IMG_H_L) &&
                     (x_off >= X_LO) && (x_off < X_HI) &&
                     (y_off >= Y_LO) && (y_off < Y_HI);
  assign o_blk_idx = {row, col};

endmodule

// File: rtl/block_color_avg.sv
// Averages R/G/B over the centre window of each tile of a 4x4 grid and hands 16 colours to the sorter.
// Latency: last pixel accepted in cycle N -> o_block* valid and o_start pulse in cycle N+2.
// Backpressure: none on pixels (one per cycle); sorter handshake is o_start pulse / i_sort_done pulse.
module block_color_avg
  import block_color_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int WIN_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_capture,
  input  logic        i_sof,
  input  logic        i_valid,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic [23:0] o_block0,
  output logic [23:0] o_block1,
  output logic [23:0] o_block2,
  output logic [23:0] o_block3,
  output logic [23:0] o_block4,
  output logic [23:0] o_block5,
  output logic [23:0] o_block6,
  output logic [23:0] o_block7,
  output logic [23:0] o_block8,
  output logic [23:0] o_block9,
  output logic [23:0] o_block10,
  output logic [23:0] o_block11,
  output logic [23:0] o_block12,
  output logic [23:0] o_block13,
  output logic [23:0] o_block14,
  output logic [23:0] o_block15,
  output logic        o_start,
  input  logic        i_sort_done,
  output logic        o_busy
);

  localparam int ACC_W = acc_width(WIN_LOG2);

  state_t state_q;
  state_t state_d;

  logic       in_win;
  logic [3:0] blk_idx;
  logic       last_px;
  logic       acc_clr;
  logic       acc_en;
  logic       latch_en;

  logic [ACC_W-1:0] acc_r [NUM_BLK];
  logic [ACC_W-1:0] acc_g [NUM_BLK];
  logic [ACC_W-1:0] acc_b [NUM_BLK];
  logic [23:0]      blk_q [NUM_BLK];

  grid_locator #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .WIN_LOG2 (WIN_LOG2)
  ) u_grid_locator (
    .i_x       (i_x),
    .i_y       (i_y),
    .o_in_win  (in_win),
    .o_blk_idx (blk_idx)
  );

  assign last_px = i_valid && (i_x == 12'(IMG_W - 1)) && (i_y == 12'(IMG_H - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a repeated start-of-frame in S_ACCUM outranks the last pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_capture)           state_d = S_WAIT_SOF;
      S_WAIT_SOF:  if (i_sof)               state_d = S_ACCUM;
      S_ACCUM:     if (!i_sof && last_px)   state_d = S_LATCH;
      S_LATCH:                              state_d = S_START;
      S_START:                              state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_sort_done)         state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from the current state.
  always_comb begin
    o_start  = 1'b0;
    o_busy   = 1'b1;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_busy  = 1'b0;
        acc_clr = i_capture;
      end
      S_ACCUM: begin
        acc_clr = i_sof;
        acc_en  = !i_sof && i_valid && in_win;
      end
      S_LATCH: latch_en = 1'b1;
      S_START: o_start  = 1'b1;
      default: ;
    endcase
  end

  // Per-tile channel sums; only the addressed tile changes on a pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        acc_r[i] <= '0;
        acc_g[i] <= '0;
        acc_b[i] <= '0;
      end
    end else if (acc_clr) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        acc_r[i] <= '0;
        acc_g[i] <= '0;
        acc_b[i] <= '0;
      end
    end else if (acc_en) begin
      acc_r[blk_idx] <= acc_r[blk_idx] + ACC_W'(i_r);
      acc_g[blk_idx] <= acc_g[blk_idx] + ACC_W'(i_g);
      acc_b[blk_idx] <= acc_b[blk_idx] + ACC_W'(i_b);
    end
  end

  // Divide by window area: the top 8 bits of each sum are sum >> (2*WIN_LOG2), truncated.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BLK; i++) blk_q[i] <= '0;
    end else if (latch_en) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        blk_q[i] <= {acc_r[i][ACC_W-1 -: 8], acc_g[i][ACC_W-1 -: 8], acc_b[i][ACC_W-1 -: 8]};
      end
    end
  end

  assign o_block0  = blk_q[0];
  assign o_block1  = blk_q[1];
  assign o_block2  = blk_q[2];
  assign o_block3  = blk_q[3];
  assign o_block4  = blk_q[4];
  assign o_block5  = blk_q[5];
  assign o_block6  = blk_q[6];
  assign o_block7  = blk_q[7];
  assign o_block8  = blk_q[8];
  assign o_block9  = blk_q[9];
  assign o_block10 = blk_q[10];
  assign o_block11 = blk_q[11];
  assign o_block12 = blk_q[12];
  assign o_block13 = blk_q[13];
  assign o_block14 = blk_q[14];
  assign o_block15 = blk_q[15];

endmodule

// File: doc/block_color_avg.md
Name: block_color_avg

Overview:
- Upstream feeder of the RGB sort stage in the klotski camera path.
- Accumulates R, G and B over a fixed square sampling window at the centre of each tile in a 4x4 grid laid over one captured frame, then divides to get 16 average colours.
- Presents the 16 averages as 24-bit {R,G,B} words and hands them to the sorter with a start pulse / done handshake.

Parameters:
- IMG_W, 640: active frame width in pixels; must be divisible by 4.
- IMG_H, 480: active frame height in pixels; must be divisible by 4.
- WIN_LOG2, 4: sampling window side is 2^WIN_LOG2 pixels; 2^WIN_LOG2 must not exceed IMG_W/4 or IMG_H/4.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_capture  input  1  request one frame measurement; honoured only in S_IDLE.
- i_sof  input  1  start-of-frame pulse from capture logic.
- i_valid  input  1  pixel qualifier for i_x/i_y/i_r/i_g/i_b.
- i_x  input  12  pixel column.
- i_y  input  12  pixel row.
- i_r, i_g, i_b  input  8 each  pixel colour.
- o_block0..o_block15  output  24 each  average colour {R[23:16],G[15:8],B[7:0]}; block index = row*4+col, block0 top-left.
- o_start  output  1  one-cycle pulse to the sorter.
- i_sort_done  input  1  sorter done pulse.
- o_busy  output  1  high in every state except S_IDLE.

Behaviour:
- Reset (async, any state, including mid-frame): state=S_IDLE; all accumulators, o_block*, o_start and o_busy are 0.
- Geometry: BLK_W=IMG_W/4, BLK_H=IMG_H/4, WIN=2^WIN_LOG2.
  - col = i_x / BLK_W; row = i_y / BLK_H.
  - The pixel is in the window when (i_x mod BLK_W) is in [(BLK_W-WIN)/2, (BLK_W-WIN)/2+WIN).
  - The same rule applies vertically using i_y and BLK_H.
  - Pixels with i_x>=IMG_W or i_y>=IMG_H are ignored.
- Accumulators: 16 blocks x 3 channels, each ACC_W = 8+2*WIN_LOG2 bits. This cannot overflow, since at most WIN^2 pixels are accumulated per block.
- FSM:
  - S_IDLE: wait for i_capture=1, then clear all accumulators and go to S_WAIT_SOF.
  - S_WAIT_SOF: wait for i_sof=1, then go to S_ACCUM. Pixels in the i_sof cycle are not accumulated.
  - S_ACCUM: on each i_valid in-window pixel, add i_r/i_g/i_b to the selected block's accumulators. Register update takes 1 cycle; one pixel per cycle, no backpressure.
    - If i_sof rises again: clear the accumulators and stay in S_ACCUM (the partial frame is discarded).
    - When a valid pixel with (i_x,i_y)=(IMG_W-1,IMG_H-1) is accepted, that pixel is accumulated if in-window, then go to S_LATCH.
  - S_LATCH: each o_block channel <= accumulator >> (2*WIN_LOG2), truncating. Go to S_START.
  - S_START: o_start=1 for exactly this cycle. Go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for i_sort_done=1, then go to S_IDLE. o_block* is held stable from S_LATCH until the next S_LATCH.
- Latency: last pixel accepted in cycle N → o_block* valid at N+2 → o_start high in N+2 only.
- i_capture outside S_IDLE is ignored.
- i_sort_done outside S_WAIT_DONE is ignored.
- i_sof outside S_WAIT_SOF/S_ACCUM is ignored.

Decomposition:
- Package block_color_pkg: state_t enum (S_IDLE, S_WAIT_SOF, S_ACCUM, S_LATCH, S_START, S_WAIT_DONE), NUM_BLK=16 and GRID=4 constants, and a function for ACC_W.
- Sub-module grid_locator (combinational, parameterised like the parent): maps i_x/i_y to o_in_win (1 bit) and o_blk_idx (4 bits).
- Accumulators, the divider shift and the FSM stay in block_color_avg.

Test Plan (IMG_W=64, IMG_H=64, WIN_LOG2=2 → BLK 16x16, window offset 6, 4x4 window):
- Uniform frame 0x204080, full capture: all 16 o_block = 0x204080; o_start is a single-cycle pulse 2 cycles after pixel (63,63); o_busy drops the cycle after i_sort_done.
- Window isolation: block k's window filled with R=G=B=k*16, all other pixels 0xFFFFFF: o_block k = {k*16,k*16,k*16} for k=0..15.
- Truncation: block 5's window has 8 pixels R=100 and 8 pixels R=101 (G=B=0): o_block5 = 0x640000.
- Restart: i_sof reasserted mid-frame after 0xFFFFFF pixels, then a full 0x102030 frame: all blocks = 0x102030.
- Handshake guards:
  - i_capture pulsed during S_ACCUM and S_WAIT_DONE has no effect.
  - i_sort_done in S_IDLE has no effect.
  - o_block* stays unchanged through S_WAIT_DONE while held 20 cycles.
- Async reset asserted mid S_ACCUM: outputs 0 immediately (before the next clock edge), state S_IDLE; the next full 0x204080 capture yields 0x204080 everywhere.
